triangle_channel: RTL and testbench
===================================

Name: triangle_channel

Overview:
Parametrised next-generation APU triangle-wave channel: timer, sequencer, linear counter, length counter and DAC code.
- Generalises DAC width, timer width and linear-counter width.
- Adds sawtooth mode, ultrasonic muting, channel-enable gating, a separate half-frame length clock and NES-exact linear-reload semantics.
- Sits between the register file (decoded $4008/$400A/$400B fields plus the $4015 enable bit) and the mixer.

Parameters:
TIMER_W, 11, timer period width in bits
LINEAR_W, 7, linear counter width in bits
DAC_W, 4, output code width; the sequencer has 2^(DAC_W+1) steps
ULTRA_MIN, 2, timer periods below this value are ultrasonic: output held at midpoint

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
timer_tick  in  1  timer clock enable (1.79 MHz rate)
enable_quarter  in  1  quarter-frame pulse (240 Hz), clocks the linear counter
enable_half  in  1  half-frame pulse (120 Hz), clocks the length counter
channel_enable  in  1  $4015 channel bit; low forces length to 0
length_halt  in  1  $4008[7], control/halt flag
linear_preset  in  LINEAR_W  linear reload value
timer_preset  in  TIMER_W  timer period
length_select  in  5  length-table index
load_strobe  in  1  one-cycle pulse on $400B write
wave_mode  in  1  0 = triangle, 1 = sawtooth
length_active  out  1  length counter non-zero (status read)
triangle_data  out  DAC_W  DAC code to mixer

Behaviour:
Clock and reset
- One clock. Reset is synchronous and active-low: on any clk edge with rst_n=0, all state takes reset values regardless of any enable, including mid-operation.
- Reset values: timer=0, sequencer=0, linear=0, reload_flag=0, length=0, timer_event=0, length_active=0, triangle_data = all-ones (the code for sequencer 0 in triangle mode).

Timer
- Only on timer_tick: if timer==0, load timer_preset and set timer_event=1; else decrement and set timer_event=0.
- timer_event is registered. It clears on the next tick, or is held for one clk only if timer_tick is continuous.

Linear counter (enable_quarter)
- If reload_flag=1, load linear_preset; else if non-zero, decrement; zero holds.
- In the same cycle, if length_halt=0, clear reload_flag.
- load_strobe sets reload_flag. If load_strobe and enable_quarter coincide, the strobe wins and the flag remains set.

Length counter
- channel_enable=0: length forced to 0 every cycle and load_strobe ignored.
- load_strobe with channel_enable=1: length = LENGTH_TABLE[length_select].
- Otherwise, on enable_half with length≠0 and length_halt=0: decrement.
- Load beats a simultaneous decrement. length_active is registered as (length≠0).

Sequencer
- Advances by 1 when timer_event=1 AND linear≠0 AND length≠0 AND timer_preset ≥ ULTRA_MIN.
- Wraps from 2^(DAC_W+1)−1 to 0.
- When gated, it holds its position; it is never reset by gating.

Output (registered, one cycle after the sequencer)
- Ultrasonic (timer_preset < ULTRA_MIN): output = 2^(DAC_W−1).
- Triangle: if seq MSB=0, output = ~seq[DAC_W−1:0]; else seq[DAC_W−1:0]. Gives F..0,0..F for DAC_W=4.
- Sawtooth: output = seq[DAC_W:1], a rising ramp with each code held two steps.
- wave_mode takes effect on the next output register update, with no sequencer disturbance.

Decomposition:
- Package apu_pkg:
  - LENGTH_TABLE[0:31] (8-bit NES length values 0A,FE,14,02,28,04,50,06,A0,08,3C,0A,0E,0C,1A,0E,0C,10,18,12,30,14,60,16,C0,18,48,1A,10,1C,20,1E)
  - wave-mode constants WAVE_TRI=0, WAVE_SAW=1
- Sub-module apu_length_counter: table lookup, enable gating, halt, half-frame decrement, length_active. It is shared with the pulse and noise channels.

Test Plan:
- Triangle timing: timer_preset=3, timer_tick=1 constant, length_select=1 (254), linear_preset=127, load_strobe → sequencer advances every 4 cycles; triangle_data F,E,…,0,0,1,…,F, period 128 cycles.
- Linear reload: length_halt=0, linear_preset=3, load_strobe, then 5 enable_quarter pulses → linear 3,2,1,0,0; sequencer freezes and output holds its last value. Repeat with length_halt=1 → reloads to 3 on every pulse.
- Length expiry and enable: length_select=3 (2), 2 enable_half pulses → length_active 1→0 and sequencer stops. channel_enable=0 then load_strobe → length stays 0.
- Ultrasonic: timer_preset=1 → triangle_data=8 constant (DAC_W=4). Set timer_preset=4 → triangle output resumes from the held sequencer position.
- Sawtooth: wave_mode=1, timer_preset=0 raised to 2, running → output 0,0,1,1,…,F,F, then wraps to 0.
- Reset mid-run: rst_n=0 for one clk while running → next cycle triangle_data=F, length_active=0, linear=0, and no advance until a new load_strobe.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU constants: the NES length-counter lookup and the waveform-select encodings.
package apu_pkg;

    localparam logic [7:0] LENGTH_TABLE [0:31] = '{
        8'h0A, 8'hFE, 8'h14, 8'h02, 8'h28, 8'h04, 8'h50, 8'h06,
        8'hA0, 8'h08, 8'h3C, 8'h0A, 8'h0E, 8'h0C, 8'h1A, 8'h0E,
        8'h0C, 8'h10, 8'h18, 8'h12, 8'h30, 8'h14, 8'h60, 8'h16,
        8'hC0, 8'h18, 8'h48, 8'h1A, 8'h10, 8'h1C, 8'h20, 8'h1E
    };

    localparam logic WAVE_TRI = 1'b0;
    localparam logic WAVE_SAW = 1'b1;

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by the pulse, triangle and noise channels: table load, enable gating,
// halt and half-frame decrement.
module apu_length_counter
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_half,
    input  logic       channel_enable,
    input  logic       length_halt,
    input  logic       load_strobe,
    input  logic [4:0] length_select,
    output logic [7:0] length,
    output logic       length_active
);

    logic [7:0] length_next;

    // A disabled channel ignores writes; a load beats a coincident decrement.
    always_comb begin
        length_next = length;
        if (!channel_enable) begin
            length_next = 8'd0;
        end else if (load_strobe) begin
            length_next = LENGTH_TABLE[length_select];
        end else if (enable_half && (length != 8'd0) && !length_halt) begin
            length_next = length - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            length        <= 8'd0;
            length_active <= 1'b0;
        end else begin
            length        <= length_next;
            length_active <= (length_next != 8'd0);
        end
    end

endmodule

// File: rtl/triangle_channel.sv
// APU triangle channel: period timer, linear counter, step sequencer and registered DAC code,
// with sawtooth mode and ultrasonic muting.
module triangle_channel
    import apu_pkg::*;
#(
    parameter int TIMER_W   = 11,
    parameter int LINEAR_W  = 7,
    parameter int DAC_W     = 4,
    parameter int ULTRA_MIN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                timer_tick,
    input  logic                enable_quarter,
    input  logic                enable_half,
    input  logic                channel_enable,
    input  logic                length_halt,
    input  logic [LINEAR_W-1:0] linear_preset,
    input  logic [TIMER_W-1:0]  timer_preset,
    input  logic [4:0]          length_select,
    input  logic                load_strobe,
    input  logic                wave_mode,
    output logic                length_active,
    output logic [DAC_W-1:0]    triangle_data
);

    localparam int SEQ_W = DAC_W + 1;
    localparam logic [TIMER_W-1:0] ULTRA_LIM = TIMER_W'(ULTRA_MIN);
    localparam logic [DAC_W-1:0]   DAC_MID   = DAC_W'(1 << (DAC_W - 1));

    logic [TIMER_W-1:0]  timer;
    logic                timer_event;
    logic [LINEAR_W-1:0] linear;
    logic                reload_flag;
    logic [SEQ_W-1:0]    seq;
    logic [7:0]          length;
    logic                ultrasonic;
    logic                seq_advance;
    logic [DAC_W-1:0]    data_next;

    apu_length_counter u_length (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_half    (enable_half),
        .channel_enable (channel_enable),
        .length_halt    (length_halt),
        .load_strobe    (load_strobe),
        .length_select  (length_select),
        .length         (length),
        .length_active  (length_active)
    );

    assign ultrasonic  = (timer_preset < ULTRA_LIM);
    assign seq_advance = timer_event && (linear != '0) && (length != 8'd0) && !ultrasonic;

    // timer_event only updates on a tick, so it stays valid across idle clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer       <= '0;
            timer_event <= 1'b0;
        end else if (timer_tick) begin
            if (timer == '0) begin
                timer       <= timer_preset;
                timer_event <= 1'b1;
            end else begin
                timer       <= timer - TIMER_W'(1);
                timer_event <= 1'b0;
            end
        end
    end

    // A $400B write wins over a coincident quarter-frame clear of the reload flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            linear      <= '0;
            reload_flag <= 1'b0;
        end else begin
            if (enable_quarter) begin
                if (reload_flag) begin
                    linear <= linear_preset;
                end else if (linear != '0) begin
                    linear <= linear - LINEAR_W'(1);
                end
            end
            if (load_strobe) begin
                reload_flag <= 1'b1;
            end else if (enable_quarter && !length_halt) begin
                reload_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (seq_advance) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    always_comb begin
        data_next = seq[DAC_W-1:0];
        if (ultrasonic) begin
            data_next = DAC_MID;
        end else begin
            case (wave_mode)
                WAVE_TRI: data_next = seq[DAC_W] ? seq[DAC_W-1:0] : ~seq[DAC_W-1:0];
                WAVE_SAW: data_next = seq[DAC_W:1];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            triangle_data <= '1;
        end else begin
            triangle_data <= data_next;
        end
    end

endmodule

// File: tb/tb_triangle_channel.sv
// Bench for triangle_channel: vector table, directed multi-cycle sequences and a randomized run
// checked every cycle against an arithmetic reference model.
module tb_triangle_channel;

    localparam int TIMER_W   = 11;
    localparam int LINEAR_W  = 7;
    localparam int DAC_W     = 4;
    localparam int ULTRA_MIN = 2;
    localparam int STEPS     = 1 << (DAC_W + 1);
    localparam int HALF      = 1 << DAC_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                timer_tick = 1'b0;
    logic                enable_quarter = 1'b0;
    logic                enable_half = 1'b0;
    logic                channel_enable = 1'b0;
    logic                length_halt = 1'b0;
    logic [LINEAR_W-1:0] linear_preset = '0;
    logic [TIMER_W-1:0]  timer_preset = '0;
    logic [4:0]          length_select = '0;
    logic                load_strobe = 1'b0;
    logic                wave_mode = 1'b0;
    logic                length_active;
    logic [DAC_W-1:0]    triangle_data;

    triangle_channel #(
        .TIMER_W(TIMER_W), .LINEAR_W(LINEAR_W), .DAC_W(DAC_W), .ULTRA_MIN(ULTRA_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .timer_tick(timer_tick), .enable_quarter(enable_quarter),
        .enable_half(enable_half), .channel_enable(channel_enable), .length_halt(length_halt),
        .linear_preset(linear_preset), .timer_preset(timer_preset), .length_select(length_select),
        .load_strobe(load_strobe), .wave_mode(wave_mode), .length_active(length_active),
        .triangle_data(triangle_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Reference model state, in plain integers
    int m_timer = 0, m_event = 0, m_seq = 0, m_lin = 0, m_rflag = 0, m_len = 0;
    int m_data = HALF - 1, m_active = 0;

    function automatic int code_of(int s, int pre, logic mode);
        if (pre < ULTRA_MIN) return HALF / 2;
        if (mode) return s / 2;
        return (s < HALF) ? (HALF - 1 - s) : (s - HALF);
    endfunction

    task automatic model_step();
        int n_timer = m_timer, n_event = m_event, n_seq = m_seq;
        int n_lin = m_lin, n_rflag = m_rflag, n_len = m_len, n_data;
        if (!rst_n) begin
            m_timer = 0; m_event = 0; m_seq = 0; m_lin = 0; m_rflag = 0; m_len = 0;
            m_data = HALF - 1; m_active = 0;
            return;
        end
        if (timer_tick) begin
            if (m_timer == 0) begin n_timer = int'(timer_preset); n_event = 1; end
            else begin n_timer = m_timer - 1; n_event = 0; end
        end
        if (enable_quarter) begin
            if (m_rflag != 0) n_lin = int'(linear_preset);
            else if (m_lin > 0) n_lin = m_lin - 1;
        end
        if (load_strobe) n_rflag = 1;
        else if (enable_quarter && !length_halt) n_rflag = 0;
        if (!channel_enable) n_len = 0;
        else if (load_strobe) n_len = len_tab[length_select];
        else if (enable_half && m_len > 0 && !length_halt) n_len = m_len - 1;
        if (m_event != 0 && m_lin > 0 && m_len > 0 && int'(timer_preset) >= ULTRA_MIN)
            n_seq = (m_seq + 1) % STEPS;
        n_data = code_of(m_seq, int'(timer_preset), wave_mode);
        m_timer = n_timer; m_event = n_event; m_seq = n_seq; m_lin = n_lin;
        m_rflag = n_rflag; m_len = n_len; m_data = n_data; m_active = (n_len != 0) ? 1 : 0;
    endtask

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model_data", int'(triangle_data), m_data);
        check("model_active", int'(length_active), m_active);
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_change(string name);
        int prev;
        prev = int'(triangle_data);
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (int'(triangle_data) != prev) return;
        end
        check(name, 0, 1);
    endtask

    typedef struct {
        logic rst_n, tick, eq, eh, ce, halt, load, mode;
        int   sel, tpre;
        int   exp_active, exp_data;
    } vec_t;

    vec_t vt [16];

    initial begin
        int d, changes;
        //          rst tick eq eh ce halt load mode sel tpre  act data
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 0, 5,  0, 15};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 3, 5,  1, 15};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 3, 5,  1, 15};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 3, 5,  0, 15};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 3, 5,  0, 15};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 0, 5,  1, 15};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0, 5,  0, 15};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1, 5,  0, 15};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 3, 5,  1, 15};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 3, 5,  1, 15};
        vt[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 3, 1,  1,  8};
        vt[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 3, 0,  1,  8};
        vt[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 3, 2,  1,  0};
        vt[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 3, 2,  1, 15};
        vt[14] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 3, 2,  1, 15};
        vt[15] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 3, 2,  0, 15};

        linear_preset = 7'd3;
        for (int i = 0; i < 16; i++) begin
            rst_n = vt[i].rst_n; timer_tick = vt[i].tick; enable_quarter = vt[i].eq;
            enable_half = vt[i].eh; channel_enable = vt[i].ce; length_halt = vt[i].halt;
            load_strobe = vt[i].load; wave_mode = vt[i].mode;
            length_select = 5'(vt[i].sel); timer_preset = TIMER_W'(vt[i].tpre);
            cyc();
            check($sformatf("vec%0d_active", i), int'(length_active), vt[i].exp_active);
            check($sformatf("vec%0d_data", i), int'(triangle_data), vt[i].exp_data);
        end
        enable_half = 1'b0; length_halt = 1'b0; wave_mode = 1'b0;

        // Triangle timing: one step every 4 clocks, full F..0,0..F shape
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        channel_enable = 1'b1; linear_preset = 7'd127; timer_preset = 11'd3; length_select = 5'd1;
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0;
        enable_quarter = 1'b1; cyc(); enable_quarter = 1'b0;
        timer_tick = 1'b1;
        wait_change("tri_start_timeout");
        for (int k = 0; k < STEPS; k++) begin
            check("tri_step", int'(triangle_data), code_of((k + 1) % STEPS, 3, 1'b0));
            cycles(4);
        end

        // Linear counter runs out after reload 3 -> sequencer freezes
        linear_preset = 7'd3; length_halt = 1'b0;
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enable_quarter = 1'b1; cyc(); enable_quarter = 1'b0; cycles(3);
        end
        d = int'(triangle_data);
        cycles(16);
        check("linear_freeze", int'(triangle_data), d);

        // With halt set the flag is never cleared, so every quarter pulse reloads
        length_halt = 1'b1;
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0;
        changes = 0;
        for (int i = 0; i < 5; i++) begin
            d = int'(triangle_data);
            enable_quarter = 1'b1; cyc(); enable_quarter = 1'b0; cycles(5);
            if (int'(triangle_data) != d) changes++;
        end
        check("linear_halt_runs", (changes >= 4) ? 1 : 0, 1);

        // Length expiry halts the sequencer; a disabled channel ignores loads
        length_halt = 1'b0; length_select = 5'd3;
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0;
        enable_half = 1'b1; cyc(); enable_half = 1'b0;
        check("len_after_1", int'(length_active), 1);
        cycles(2);
        enable_half = 1'b1; cyc(); enable_half = 1'b0;
        check("len_after_2", int'(length_active), 0);
        d = int'(triangle_data);
        cycles(16);
        check("len_freeze", int'(triangle_data), d);
        channel_enable = 1'b0; cyc();
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0; cyc();
        check("disabled_load", int'(length_active), 0);

        // Ultrasonic mute then resume
        channel_enable = 1'b1; length_select = 5'd1; linear_preset = 7'd100;
        load_strobe = 1'b1; cyc(); load_strobe = 1'b0;
        enable_quarter = 1'b1; cyc(); enable_quarter = 1'b0;
        cycles(7);
        timer_preset = 11'd1; cycles(2);
        for (int i = 0; i < 10; i++) begin
            check("ultra_mid", int'(triangle_data), HALF / 2);
            cyc();
        end
        timer_preset = 11'd4; cycles(30);

        // Sawtooth ramp at timer period 2 (3 clocks per step), including wrap
        timer_preset = 11'd0; wave_mode = 1'b1; cycles(2);
        check("saw_ultra", int'(triangle_data), HALF / 2);
        timer_preset = 11'd2; cyc();
        wait_change("saw_start_timeout");
        d = int'(triangle_data);
        for (int k = 0; k < STEPS; k++) begin
            check("saw_step", int'(triangle_data), ((2 * d + k) % STEPS) / 2);
            cycles(3);
        end

        // Reset mid-run
        wave_mode = 1'b0; timer_preset = 11'd4; cycles(10);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("rst_data", int'(triangle_data), HALF - 1);
        check("rst_active", int'(length_active), 0);
        for (int i = 0; i < 20; i++) cyc();
        check("rst_hold_data", int'(triangle_data), HALF - 1);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n          = ($urandom_range(599) != 0);
            timer_tick     = ($urandom_range(3) != 0);
            enable_quarter = ($urandom_range(31) == 0);
            enable_half    = ($urandom_range(15) == 0);
            channel_enable = ($urandom_range(31) != 0);
            length_halt    = ($urandom_range(3) == 0);
            load_strobe    = ($urandom_range(47) == 0);
            linear_preset  = LINEAR_W'($urandom_range(60));
            length_select  = 5'($urandom_range(31));
            if ($urandom_range(63) == 0) timer_preset = TIMER_W'($urandom_range(7));
            if ($urandom_range(127) == 0) wave_mode = ~wave_mode;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
